// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-master memory arbiter: FSM states and master indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Valid/ready request + response bundle used on both master ports and the memory port.
// The master modport is the side that issues requests; the slave modport serves them.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   addr;
    logic            wen;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wmask;
    logic            resp_valid;
    logic            resp_ready;
    logic [DW-1:0]   rdata;

    modport master (
        output req_valid, addr, wen, wdata, wmask, resp_ready,
        input  req_ready, resp_valid, rdata
    );

    modport slave (
        input  req_valid, addr, wen, wdata, wmask, resp_ready,
        output req_ready, resp_valid, rdata
    );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner select for the arbiter's IDLE cycle.
// MEM_ARBITER_RR_EN selects round-robin; otherwise the LSU (M1) has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic any_req,
    output logic winner
);

`ifdef MEM_ARBITER_RR_EN
    // On contention the master that was not served last goes next.
    always_comb begin
        any_req = req0 | req1;
        winner  = MST_IFU;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = MST_LSU;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        any_req = req0 | req1;
        winner  = MST_IFU;
        if (req1) begin
            winner = MST_LSU;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch (M0) and load/store (M1),
// one transaction in flight. Define MEM_ARBITER_RR_EN for round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic          busy
);

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;
    logic   busy_q, busy_d;
    logic   any_req;
    logic   winner;
    logic   s_req_hs;
    logic   s_resp_hs;

    arb_pick u_pick (
        .req0       (m0.req_valid),
        .req1       (m1.req_valid),
        .last_grant (last_grant_q),
        .any_req    (any_req),
        .winner     (winner)
    );

    assign s_req_hs  = (state_q == ST_REQ)  && s.req_ready;
    assign s_resp_hs = (state_q == ST_RESP) && s.resp_valid && s.resp_ready;

    // The grant is only sampled in IDLE, so no master valid ever reaches a ready combinationally.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (s_req_hs) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (s_resp_hs) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_comb begin
        s.req_valid   = 1'b0;
        s.addr        = {AW{1'b0}};
        s.wen         = 1'b0;
        s.wdata       = {DW{1'b0}};
        s.wmask       = {(DW/8){1'b0}};
        s.resp_ready  = 1'b0;
        m0.req_ready  = 1'b0;
        m0.resp_valid = 1'b0;
        m0.rdata      = {DW{1'b0}};
        m1.req_ready  = 1'b0;
        m1.resp_valid = 1'b0;
        m1.rdata      = {DW{1'b0}};
        case (state_q)
            ST_REQ: begin
                s.req_valid = 1'b1;
                if (grant_q == MST_LSU) begin
                    s.addr       = m1.addr;
                    s.wen        = m1.wen;
                    s.wdata      = m1.wdata;
                    s.wmask      = m1.wmask;
                    m1.req_ready = s.req_ready;
                end else begin
                    s.addr       = m0.addr;
                    s.wen        = m0.wen;
                    s.wdata      = m0.wdata;
                    s.wmask      = m0.wmask;
                    m0.req_ready = s.req_ready;
                end
            end
            ST_RESP: begin
                if (grant_q == MST_LSU) begin
                    s.resp_ready  = m1.resp_ready;
                    m1.resp_valid = s.resp_valid;
                    m1.rdata      = s.rdata;
                end else begin
                    s.resp_ready  = m0.resp_ready;
                    m0.resp_valid = s.resp_valid;
                    m0.rdata      = s.rdata;
                end
            end
            default: begin
            end
        endcase
    end

    // last_grant resets to LSU so the first contended round-robin pick favours fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= MST_IFU;
            last_grant_q <= MST_LSU;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
        end
    end

    assign busy = busy_q;

`ifndef SYNTHESIS
    logic gnt_req_valid;
    assign gnt_req_valid = (grant_q == MST_LSU) ? m1.req_valid : m0.req_valid;

    // A granted master withdrawing its request before acceptance breaks the handshake contract.
    req_held_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_REQ) |-> gnt_req_valid);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of expected memory requests and responses.
// Expected arbitration order follows MEM_ARBITER_RR_EN when that macro is defined.
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } resp_t;

    logic clk;
    logic rst;
    logic busy;

    int check_count = 0;
    int pass_count  = 0;
    logic last_grant = 1'b1;

    req_t  exp_req_m0[$];
    req_t  exp_req_m1[$];
    resp_t exp_resp_m0[$];
    resp_t exp_resp_m1[$];
    logic  exp_owner[$];

    mem_arbiter_if #(.AW(32), .DW(32)) m0_if ();
    mem_arbiter_if #(.AW(32), .DW(32)) m1_if ();
    mem_arbiter_if #(.AW(32), .DW(32)) s_if ();

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .m0   (m0_if),
        .m1   (m1_if),
        .s    (s_if),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h8000_0000) return 32'h0000_0297;
        return addr ^ 32'h5A5A_0F0F;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic mst, input logic [31:0] addr, input logic wen,
                                 input logic [31:0] wdata, input logic [3:0] wmask, input bit track);
        req_t  r;
        resp_t p;
        r.addr  = addr;
        r.wen   = wen;
        r.wdata = wdata;
        r.wmask = wmask;
        p.chk   = !wen;
        p.data  = mem_data(addr);
        if (mst) begin
            m1_if.req_valid = 1'b1;
            m1_if.addr      = addr;
            m1_if.wen       = wen;
            m1_if.wdata     = wdata;
            m1_if.wmask     = wmask;
            if (track) begin
                exp_req_m1.push_back(r);
                exp_resp_m1.push_back(p);
            end
        end else begin
            m0_if.req_valid = 1'b1;
            m0_if.addr      = addr;
            m0_if.wen       = wen;
            m0_if.wdata     = wdata;
            m0_if.wmask     = wmask;
            if (track) begin
                exp_req_m0.push_back(r);
                exp_resp_m0.push_back(p);
            end
        end
    endtask

    task automatic dropRequest(input logic mst);
        if (mst) begin
            m1_if.req_valid = 1'b0;
            m1_if.addr      = '0;
            m1_if.wen       = 1'b0;
            m1_if.wdata     = '0;
            m1_if.wmask     = '0;
        end else begin
            m0_if.req_valid = 1'b0;
            m0_if.addr      = '0;
            m0_if.wen       = 1'b0;
            m0_if.wdata     = '0;
            m0_if.wmask     = '0;
        end
    endtask

    // Called in the IDLE cycle where mst's request is sampled; serves it with minimum latency.
    task automatic completeTxn(input logic mst, input logic [31:0] addr, input logic wen);
        nextCycle();
        s_if.req_ready = 1'b1;
        settle();
        checkOutput("gnt_req_ready", mst ? m1_if.req_ready : m0_if.req_ready, 1);
        checkOutput("other_req_ready", mst ? m0_if.req_ready : m1_if.req_ready, 0);
        checkOutput("busy_in_req", busy, 1);
        nextCycle();
        dropRequest(mst);
        s_if.req_ready  = 1'b0;
        s_if.resp_valid = 1'b1;
        s_if.rdata      = wen ? 32'hFFFF_FFFF : mem_data(addr);
        settle();
        checkOutput("gnt_resp_valid", mst ? m1_if.resp_valid : m0_if.resp_valid, 1);
        checkOutput("other_resp_valid", mst ? m0_if.resp_valid : m1_if.resp_valid, 0);
        checkOutput("other_rdata", mst ? m0_if.rdata : m1_if.rdata, 0);
        nextCycle();
        s_if.resp_valid = 1'b0;
        s_if.rdata      = '0;
        settle();
        checkOutput("busy_after_resp", busy, 0);
        last_grant = mst;
    endtask

    task automatic runPair(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd1);
        logic first;
        $display("[TB] contended pair, last grant M%0d", last_grant);
`ifdef MEM_ARBITER_RR_EN
        first = ~last_grant;
`else
        first = 1'b1;
`endif
        nextCycle();
        applyStimulus(1'b0, a0, 1'b0, 32'h0, 4'h0, 1'b1);
        applyStimulus(1'b1, a1, 1'b1, wd1, 4'hF, 1'b1);
        exp_owner.push_back(first);
        exp_owner.push_back(~first);
        settle();
        checkOutput("pair_idle_busy", busy, 0);
        completeTxn(first, first ? a1 : a0, first);
        completeTxn(~first, first ? a0 : a1, ~first);
    endtask

    task automatic checkSlaveReq();
        logic own;
        req_t e;
        checkOutput("s_req_expected", exp_owner.size() != 0, 1);
        if (exp_owner.size() != 0) begin
            own = exp_owner.pop_front();
            if (own) e = exp_req_m1.pop_front();
            else     e = exp_req_m0.pop_front();
            checkOutput("s_addr", s_if.addr, e.addr);
            checkOutput("s_wen", s_if.wen, e.wen);
            checkOutput("s_wdata", s_if.wdata, e.wdata);
            checkOutput("s_wmask", s_if.wmask, e.wmask);
        end
    endtask

    task automatic checkResp(input logic mst);
        resp_t e;
        if (mst) begin
            checkOutput("m1_resp_expected", exp_resp_m1.size() != 0, 1);
            if (exp_resp_m1.size() != 0) begin
                e = exp_resp_m1.pop_front();
                if (e.chk) checkOutput("m1_rdata", m1_if.rdata, e.data);
            end
        end else begin
            checkOutput("m0_resp_expected", exp_resp_m0.size() != 0, 1);
            if (exp_resp_m0.size() != 0) begin
                e = exp_resp_m0.pop_front();
                if (e.chk) checkOutput("m0_rdata", m0_if.rdata, e.data);
            end
        end
    endtask

    // Handshakes are observed mid-cycle, when both sides have settled for the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && s_if.req_valid && s_if.req_ready) checkSlaveReq();
            if (!rst && m0_if.resp_valid && m0_if.resp_ready) checkResp(1'b0);
            if (!rst && m1_if.resp_valid && m1_if.resp_ready) checkResp(1'b1);
        end
    end

    initial begin
        rst = 1'b1;
        dropRequest(1'b0);
        dropRequest(1'b1);
        m0_if.resp_ready = 1'b1;
        m1_if.resp_ready = 1'b1;
        s_if.req_ready   = 1'b1;
        s_if.resp_valid  = 1'b1;
        s_if.rdata       = 32'hCAFE_F00D;

        // Reset state, with memory-side inputs deliberately active.
        nextCycle();
        nextCycle();
        settle();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_s_req_valid", s_if.req_valid, 0);
        checkOutput("rst_s_resp_ready", s_if.resp_ready, 0);
        checkOutput("rst_m0_req_ready", m0_if.req_ready, 0);
        checkOutput("rst_m1_req_ready", m1_if.req_ready, 0);
        checkOutput("rst_m0_resp_valid", m0_if.resp_valid, 0);
        checkOutput("rst_m1_resp_valid", m1_if.resp_valid, 0);
        checkOutput("rst_s_addr", s_if.addr, 0);
        checkOutput("rst_s_wen", s_if.wen, 0);
        checkOutput("rst_s_wdata", s_if.wdata, 0);
        checkOutput("rst_s_wmask", s_if.wmask, 0);
        checkOutput("rst_m0_rdata", m0_if.rdata, 0);
        checkOutput("rst_m1_rdata", m1_if.rdata, 0);

        // Single M0 read, cycle by cycle.
        nextCycle();
        rst = 1'b0;
        s_if.req_ready  = 1'b0;
        s_if.resp_valid = 1'b0;
        s_if.rdata      = '0;
        applyStimulus(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b1);
        exp_owner.push_back(1'b0);
        settle();
        checkOutput("t1_c0_busy", busy, 0);
        checkOutput("t1_c0_m0_req_ready", m0_if.req_ready, 0);
        checkOutput("t1_c0_s_req_valid", s_if.req_valid, 0);
        nextCycle();
        settle();
        checkOutput("t1_c1_busy", busy, 1);
        checkOutput("t1_c1_s_req_valid", s_if.req_valid, 1);
        checkOutput("t1_c1_s_addr", s_if.addr, 32'h8000_0000);
        checkOutput("t1_c1_m0_req_ready", m0_if.req_ready, 0);
        nextCycle();
        s_if.req_ready = 1'b1;
        settle();
        checkOutput("t1_c2_m0_req_ready", m0_if.req_ready, 1);
        checkOutput("t1_c2_busy", busy, 1);
        nextCycle();
        dropRequest(1'b0);
        s_if.req_ready  = 1'b0;
        s_if.resp_valid = 1'b1;
        s_if.rdata      = mem_data(32'h8000_0000);
        settle();
        checkOutput("t1_c3_m0_resp_valid", m0_if.resp_valid, 1);
        checkOutput("t1_c3_m0_rdata", m0_if.rdata, 32'h0000_0297);
        checkOutput("t1_c3_busy", busy, 1);
        checkOutput("t1_c3_s_resp_ready", s_if.resp_ready, 1);
        checkOutput("t1_c3_s_req_valid", s_if.req_valid, 0);
        nextCycle();
        s_if.resp_valid = 1'b0;
        s_if.rdata      = '0;
        settle();
        checkOutput("t1_c4_busy", busy, 0);
        checkOutput("t1_c4_m0_resp_valid", m0_if.resp_valid, 0);
        last_grant = 1'b0;

        // Contention, then a lone M1 access so the second pair starts from last_grant = M1.
        runPair(32'h8000_0004, 32'h8000_1000, 32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 1'b1);
        exp_owner.push_back(1'b1);
        completeTxn(1'b1, 32'h8000_3000, 1'b0);
        runPair(32'h8000_0008, 32'h8000_1004, 32'h1234_5678);

        // Memory holds off request acceptance for five cycles.
        nextCycle();
        applyStimulus(1'b0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 1'b1);
        exp_owner.push_back(1'b0);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            settle();
            checkOutput("t3_s_req_valid", s_if.req_valid, 1);
            checkOutput("t3_s_addr", s_if.addr, 32'h8000_0010);
            checkOutput("t3_m0_req_ready", m0_if.req_ready, 0);
            checkOutput("t3_m1_req_ready", m1_if.req_ready, 0);
        end
        completeTxn(1'b0, 32'h8000_0010, 1'b0);

        // M1 stalls its response while M0 waits behind it.
        nextCycle();
        applyStimulus(1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'h0, 1'b1);
        exp_owner.push_back(1'b1);
        nextCycle();
        s_if.req_ready = 1'b1;
        applyStimulus(1'b0, 32'h8000_0030, 1'b0, 32'h0, 4'h0, 1'b1);
        exp_owner.push_back(1'b0);
        settle();
        checkOutput("t4_m1_req_ready", m1_if.req_ready, 1);
        checkOutput("t4_m0_req_ready", m0_if.req_ready, 0);
        nextCycle();
        dropRequest(1'b1);
        s_if.req_ready   = 1'b0;
        s_if.resp_valid  = 1'b1;
        s_if.rdata       = mem_data(32'h8000_2000);
        m1_if.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checkOutput("t4_s_resp_ready", s_if.resp_ready, 0);
            checkOutput("t4_m1_resp_valid", m1_if.resp_valid, 1);
            checkOutput("t4_busy", busy, 1);
            checkOutput("t4_m0_req_ready", m0_if.req_ready, 0);
            checkOutput("t4_s_req_valid", s_if.req_valid, 0);
            nextCycle();
        end
        m1_if.resp_ready = 1'b1;
        settle();
        checkOutput("t4_release_s_resp_ready", s_if.resp_ready, 1);
        nextCycle();
        s_if.resp_valid = 1'b0;
        s_if.rdata      = '0;
        settle();
        checkOutput("t4_idle_busy", busy, 0);
        checkOutput("t4_idle_m0_req_ready", m0_if.req_ready, 0);
        last_grant = 1'b1;
        completeTxn(1'b0, 32'h8000_0030, 1'b0);

        // Reset while a request waits for acceptance; that transaction is simply lost.
        nextCycle();
        applyStimulus(1'b0, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 1'b0);
        nextCycle();
        settle();
        checkOutput("t5_in_req", s_if.req_valid, 1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        dropRequest(1'b0);
        settle();
        checkOutput("t5_s_req_valid", s_if.req_valid, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_m0_req_ready", m0_if.req_ready, 0);
        last_grant = 1'b1;
        nextCycle();
        applyStimulus(1'b0, 32'h8000_0024, 1'b0, 32'h0, 4'h0, 1'b1);
        exp_owner.push_back(1'b0);
        completeTxn(1'b0, 32'h8000_0024, 1'b0);

        nextCycle();
        nextCycle();
        checkOutput("owner_queue_drained", exp_owner.size(), 0);
        checkOutput("m0_resp_queue_drained", exp_resp_m0.size(), 0);
        checkOutput("m1_resp_queue_drained", exp_resp_m1.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
